// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic array.
package sys_array_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    SWAP_WAIT = 1'b1
  } state_e;

  function automatic int psum_width(int data_w, int rows);
    return 2 * data_w + $clog2(rows);
  endfunction

  function automatic int latency(int rows, int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sys_pe_ws.sv
// One weight-stationary PE: holds an active weight, passes activations right
// and accumulates partial sums downward.
module sys_pe_ws #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 36,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_load,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic [DATA_WIDTH-1:0] act_in,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic [DATA_WIDTH-1:0] act_out,
  output logic [PSUM_WIDTH-1:0] psum_out
);

  localparam int EXT = PSUM_WIDTH - DATA_WIDTH;
  localparam bit SX  = (SIGNED != 0);

  logic [DATA_WIDTH-1:0] weight_q;
  logic [DATA_WIDTH-1:0] act_q;
  logic [PSUM_WIDTH-1:0] psum_q;
  logic [PSUM_WIDTH-1:0] act_x;
  logic [PSUM_WIDTH-1:0] w_x;
  logic [PSUM_WIDTH-1:0] prod;

  // Extending to the full psum width makes the truncated product exact mod 2^PSUM_WIDTH.
  always_comb begin
    act_x = {{EXT{SX & act_in[DATA_WIDTH-1]}}, act_in};
    w_x   = {{EXT{SX & weight_q[DATA_WIDTH-1]}}, weight_q};
    prod  = act_x * w_x;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      weight_q <= '0;
      act_q    <= '0;
      psum_q   <= '0;
    end else begin
      if (w_load) weight_q <= w_in;
      act_q  <= act_in;
      psum_q <= psum_in + prod;
    end
  end

  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/sys_array_ws.sv
// Weight-stationary systolic array with shadow/active weights, input skew,
// output deskew and a swap FSM that drains the pipe before copying weights.
module sys_array_ws
  import sys_array_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SIGNED     = 1,
  localparam int PSUM_WIDTH = psum_width(DATA_WIDTH, SYS_ROW),
  localparam int LAT        = latency(SYS_ROW, SYS_COL),
  localparam int RW         = (SYS_ROW > 2) ? $clog2(SYS_ROW) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SYS_ROW*DATA_WIDTH-1:0] in_data,
  input  logic                          w_load_valid,
  input  logic [RW-1:0]                 w_load_row,
  input  logic [SYS_COL*DATA_WIDTH-1:0] w_load_data,
  input  logic                          w_swap,
  output logic                          swap_done,
  output logic                          out_valid,
  output logic [SYS_COL*PSUM_WIDTH-1:0] out_data
);

  localparam int IW = $clog2(LAT + 2);

  logic [DATA_WIDTH-1:0]         act_w   [SYS_ROW][SYS_COL+1];
  logic [PSUM_WIDTH-1:0]         psum_w  [SYS_ROW+1][SYS_COL];
  logic [SYS_COL*DATA_WIDTH-1:0] shadow_q[SYS_ROW];

  logic [LAT-1:0] vld_q;
  logic [IW-1:0]  inflight_q;
  state_e         state_q, state_d;
  logic           swap_done_q;
  logic           ready_raw;
  logic           copy;
  logic           accept;

  always_comb begin
    state_d   = state_q;
    ready_raw = 1'b0;
    copy      = 1'b0;
    unique case (state_q)
      RUN: begin
        ready_raw = !w_swap;
        if (w_swap) state_d = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        // Extra w_swap pulses here simply merge into the pending swap.
        if (inflight_q == '0) begin
          copy    = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  assign in_ready  = rstn & ready_raw;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_q[LAT-1];
  assign swap_done = swap_done_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RUN;
      swap_done_q <= 1'b0;
      vld_q       <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= copy;
      vld_q       <= (vld_q << 1) | LAT'(accept);
      case ({accept, out_valid})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: ;
      endcase
    end
  end

  // Out-of-range row indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < SYS_ROW; r++) shadow_q[r] <= '0;
    end else if (w_load_valid) begin
      for (int r = 0; r < SYS_ROW; r++) begin
        if (w_load_row == RW'(r)) shadow_q[r] <= w_load_data;
      end
    end
  end

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    logic [DATA_WIDTH-1:0] lane;
    assign lane = accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (r == 0) begin : g_direct
      assign act_w[r][0] = lane;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] skew_q[r];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < r; k++) skew_q[k] <= '0;
        end else begin
          skew_q[0] <= lane;
          for (int k = 1; k < r; k++) skew_q[k] <= skew_q[k-1];
        end
      end
      assign act_w[r][0] = skew_q[r-1];
    end

    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
      sys_pe_ws #(
        .DATA_WIDTH(DATA_WIDTH),
        .PSUM_WIDTH(PSUM_WIDTH),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk     (clk),
        .rstn    (rstn),
        .w_load  (copy),
        .w_in    (shadow_q[r][c*DATA_WIDTH +: DATA_WIDTH]),
        .act_in  (act_w[r][c]),
        .psum_in (psum_w[r][c]),
        .act_out (act_w[r][c+1]),
        .psum_out(psum_w[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < SYS_COL; c++) begin : g_deskew
    localparam int D = SYS_COL - 1 - c;
    assign psum_w[0][c] = '0;

    if (D == 0) begin : g_direct
      assign out_data[c*PSUM_WIDTH +: PSUM_WIDTH] = psum_w[SYS_ROW][c];
    end else begin : g_dly
      logic [PSUM_WIDTH-1:0] dly_q[D];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int k = 0; k < D; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= psum_w[SYS_ROW][c];
          for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign out_data[c*PSUM_WIDTH +: PSUM_WIDTH] = dly_q[D-1];
    end
  end

endmodule

// File: tb/tb_sys_array_ws.sv
// Directed bench for sys_array_ws: 4x4, 16x16 and 2x2 signed/unsigned instances.
module tb_sys_array_ws;

  localparam int DW   = 16;
  localparam int AR   = 4;
  localparam int AC   = 4;
  localparam int APW  = 2 * DW + 2;
  localparam int ALAT = 7;
  localparam int BR   = 16;
  localparam int BC   = 16;
  localparam int BPW  = 2 * DW + 4;
  localparam int BLAT = 31;
  localparam int CR   = 2;
  localparam int CC   = 2;
  localparam int CPW  = 2 * DW + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 4x4 instance
  logic             a_in_valid, a_in_ready, a_w_load_valid, a_w_swap, a_swap_done, a_out_valid;
  logic [AR*DW-1:0] a_in_data;
  logic [1:0]       a_w_load_row;
  logic [AC*DW-1:0] a_w_load_data;
  logic [AC*APW-1:0] a_out_data;

  // 16x16 instance
  logic             b_in_valid, b_in_ready, b_w_load_valid, b_w_swap, b_swap_done, b_out_valid;
  logic [BR*DW-1:0] b_in_data;
  logic [3:0]       b_w_load_row;
  logic [BC*DW-1:0] b_w_load_data;
  logic [BC*BPW-1:0] b_out_data;

  // 2x2 signed and unsigned instances share their inputs
  logic             c_in_valid, c_w_load_valid, c_w_swap;
  logic             cs_in_ready, cs_swap_done, cs_out_valid;
  logic             cu_in_ready, cu_swap_done, cu_out_valid;
  logic [CR*DW-1:0] c_in_data;
  logic [0:0]       c_w_load_row;
  logic [CC*DW-1:0] c_w_load_data;
  logic [CC*CPW-1:0] cs_out_data, cu_out_data;

  sys_array_ws #(.SYS_ROW(AR), .SYS_COL(AC), .DATA_WIDTH(DW), .SIGNED(1)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .w_load_valid(a_w_load_valid), .w_load_row(a_w_load_row),
    .w_load_data(a_w_load_data), .w_swap(a_w_swap), .swap_done(a_swap_done),
    .out_valid(a_out_valid), .out_data(a_out_data)
  );

  sys_array_ws #(.SYS_ROW(BR), .SYS_COL(BC), .DATA_WIDTH(DW), .SIGNED(1)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .w_load_valid(b_w_load_valid), .w_load_row(b_w_load_row),
    .w_load_data(b_w_load_data), .w_swap(b_w_swap), .swap_done(b_swap_done),
    .out_valid(b_out_valid), .out_data(b_out_data)
  );

  sys_array_ws #(.SYS_ROW(CR), .SYS_COL(CC), .DATA_WIDTH(DW), .SIGNED(1)) u_cs (
    .clk(clk), .rstn(rstn), .in_valid(c_in_valid), .in_ready(cs_in_ready),
    .in_data(c_in_data), .w_load_valid(c_w_load_valid), .w_load_row(c_w_load_row),
    .w_load_data(c_w_load_data), .w_swap(c_w_swap), .swap_done(cs_swap_done),
    .out_valid(cs_out_valid), .out_data(cs_out_data)
  );

  sys_array_ws #(.SYS_ROW(CR), .SYS_COL(CC), .DATA_WIDTH(DW), .SIGNED(0)) u_cu (
    .clk(clk), .rstn(rstn), .in_valid(c_in_valid), .in_ready(cu_in_ready),
    .in_data(c_in_data), .w_load_valid(c_w_load_valid), .w_load_row(c_w_load_row),
    .w_load_data(c_w_load_data), .w_swap(c_w_swap), .swap_done(cu_swap_done),
    .out_valid(cu_out_valid), .out_data(cu_out_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill(input int n, input logic [15:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic a_load_row(input int r, input logic [AC*DW-1:0] d);
    @(negedge clk);
    a_w_load_valid = 1'b1;
    a_w_load_row   = 2'(r);
    a_w_load_data  = d;
  endtask

  // Request at t, expect in_ready/swap_done high at t+2; returns inside cycle t+2.
  task automatic a_swap(input string tag);
    @(negedge clk);
    a_w_load_valid = 1'b0;
    a_w_swap       = 1'b1;
    #1 check({tag, "_req_ready"}, 64'(a_in_ready), 64'd0);
    @(negedge clk);
    a_w_swap = 1'b0;
    #1 check({tag, "_wait_ready"}, 64'(a_in_ready), 64'd0);
    check({tag, "_wait_done"}, 64'(a_swap_done), 64'd0);
    @(negedge clk);
    #1 check({tag, "_done"}, 64'(a_swap_done), 64'd1);
    check({tag, "_ready"}, 64'(a_in_ready), 64'd1);
  endtask

  int     q_cyc[$];
  longint q_val[$];

  initial begin
    int     sent;
    int     n_done;
    int     ec;
    longint ev;

    {a_in_valid, a_w_load_valid, a_w_swap} = '0;
    a_in_data = '0; a_w_load_row = '0; a_w_load_data = '0;
    {b_in_valid, b_w_load_valid, b_w_swap} = '0;
    b_in_data = '0; b_w_load_row = '0; b_w_load_data = '0;
    {c_in_valid, c_w_load_valid, c_w_swap} = '0;
    c_in_data = '0; c_w_load_row = '0; c_w_load_data = '0;

    // Reset held with random stimulus on the 4x4 instance
    rstn = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in_valid     = 1'($urandom);
      a_in_data      = {$urandom, $urandom};
      a_w_load_valid = 1'($urandom);
      a_w_load_row   = 2'($urandom);
      a_w_load_data  = {$urandom, $urandom};
      a_w_swap       = 1'($urandom);
      #1 check("rst_in_ready", 64'(a_in_ready), 64'd0);
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_out_data", 64'(|a_out_data), 64'd0);
      check("rst_swap_done", 64'(a_swap_done), 64'd0);
    end
    for (int i = 0; i < ALAT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        {a_in_valid, a_w_load_valid, a_w_swap} = '0;
        rstn = 1'b1;
      end
      #1 check("rel_in_ready", 64'(a_in_ready), 64'd1);
      check("rel_out_valid", 64'(a_out_valid), 64'd0);
      check("rel_swap_done", 64'(a_swap_done), 64'd0);
    end

    // 4x4 identity
    for (int r = 0; r < AR; r++) a_load_row(r, 64'h1 << (r * 16));
    a_swap("id_swap");
    a_in_valid = 1'b1;
    a_in_data  = 64'h0004_0003_0002_0001;
    for (int k = 1; k <= ALAT; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      if (k == 1) check("id_done_pulse", 64'(a_swap_done), 64'd0);
      if (k == ALAT - 1) check("id_early_valid", 64'(a_out_valid), 64'd0);
      if (k == ALAT) begin
        check("id_valid", 64'(a_out_valid), 64'd1);
        for (int c = 0; c < AC; c++) check("id_lane", 64'(a_out_data[c*APW +: APW]), 64'(c + 1));
      end
    end

    // Mid-stream swap: active all 1, shadow all 2 loaded while streaming
    for (int r = 0; r < AR; r++) a_load_row(r, fill(AC, 16'd1)[AC*DW-1:0]);
    a_swap("sw_pre");
    sent   = 0;
    n_done = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (a_out_valid) begin
        if (q_cyc.size() == 0) check("sw_spurious_valid", 64'd1, 64'd0);
        else begin
          ec = q_cyc.pop_front();
          ev = q_val.pop_front();
          check("sw_out_cycle", 64'(i), 64'(ec));
          for (int c = 0; c < AC; c++) check("sw_lane", 64'(a_out_data[c*APW +: APW]), 64'(ev));
        end
      end
      if (a_swap_done) n_done++;
      a_in_valid     = (sent < 10);
      a_in_data      = fill(AR, 16'(sent + 1))[AR*DW-1:0];
      a_w_load_valid = (i >= 1 && i <= 4);
      a_w_load_row   = 2'(i - 1);
      a_w_load_data  = fill(AC, 16'd2)[AC*DW-1:0];
      a_w_swap       = (i == 6 || i == 8);
      #1;
      if (a_in_valid && a_in_ready) begin
        q_cyc.push_back(i + ALAT);
        q_val.push_back(longint'(4 * (sent + 1) * ((sent <= 5) ? 1 : 2)));
        if (sent == 6) check("sw_resume_cycle", 64'(i), 64'd14);
        sent++;
      end
    end
    a_in_valid = 1'b0;
    a_w_swap   = 1'b0;
    a_w_load_valid = 1'b0;
    check("sw_sent", 64'(sent), 64'd10);
    check("sw_drained", 64'(q_cyc.size()), 64'd0);
    check("sw_done_count", 64'(n_done), 64'd1);

    // 16x16 streaming, all-ones weights
    for (int r = 0; r < BR; r++) begin
      @(negedge clk);
      b_w_load_valid = 1'b1;
      b_w_load_row   = 4'(r);
      b_w_load_data  = fill(BC, 16'd1);
    end
    @(negedge clk);
    b_w_load_valid = 1'b0;
    b_w_swap       = 1'b1;
    @(negedge clk);
    b_w_swap = 1'b0;
    @(negedge clk);
    #1 check("b_swap_done", 64'(b_swap_done), 64'd1);
    sent = 0;
    q_cyc.delete();
    q_val.delete();
    for (int i = 0; i < 20 + BLAT + 2; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        if (q_cyc.size() == 0) check("b_spurious_valid", 64'd1, 64'd0);
        else begin
          ec = q_cyc.pop_front();
          ev = q_val.pop_front();
          check("b_out_cycle", 64'(i), 64'(ec));
          for (int c = 0; c < BC; c++) check("b_lane", 64'(b_out_data[c*BPW +: BPW]), 64'(ev));
        end
      end
      b_in_valid = (sent < 20);
      b_in_data  = fill(BR, 16'(sent + 1));
      #1;
      if (b_in_valid && b_in_ready) begin
        q_cyc.push_back(i + BLAT);
        q_val.push_back(longint'(16 * (sent + 1)));
        sent++;
      end
    end
    b_in_valid = 1'b0;
    check("b_sent", 64'(sent), 64'd20);
    check("b_drained", 64'(q_cyc.size()), 64'd0);

    // 2x2 signed vs unsigned: row0 W=0xFFFF, row1 W=2
    @(negedge clk);
    c_w_load_valid = 1'b1;
    c_w_load_row   = 1'b0;
    c_w_load_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    c_w_load_row  = 1'b1;
    c_w_load_data = 32'h0002_0002;
    @(negedge clk);
    c_w_load_valid = 1'b0;
    c_w_swap       = 1'b1;
    @(negedge clk);
    c_w_swap = 1'b0;
    @(negedge clk);
    #1 check("c_swap_done", 64'(cs_swap_done & cu_swap_done), 64'd1);
    c_in_valid = 1'b1;
    c_in_data  = 32'h0000_8000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      c_in_valid = (k == 1);
      c_in_data  = 32'h8000_0003;
      #1;
      if (k == 2) check("c_early_valid", 64'(cs_out_valid | cu_out_valid), 64'd0);
      if (k == 3) begin
        check("cs_valid1", 64'(cs_out_valid), 64'd1);
        check("cu_valid1", 64'(cu_out_valid), 64'd1);
        for (int c = 0; c < CC; c++) begin
          check("cs_neg_neg", 64'(cs_out_data[c*CPW +: CPW]), 64'd32768);
          check("cu_big", 64'(cu_out_data[c*CPW +: CPW]), 64'h7FFF_8000);
        end
      end
      if (k == 4) begin
        for (int c = 0; c < CC; c++) begin
          check("cs_negative", 64'(cs_out_data[c*CPW +: CPW]), 64'h1_FFFE_FFFD);
          check("cu_mixed", 64'(cu_out_data[c*CPW +: CPW]), 64'd262141);
        end
      end
    end
    c_in_valid = 1'b0;

    // Reset mid-stream on the 4x4 instance (active weights all 2)
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = fill(AR, 16'(i + 1))[AR*DW-1:0];
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    rstn       = 1'b0;
    #1 check("mid_rst_ready", 64'(a_in_ready), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) rstn = 1'b1;
      #1 check("mid_rst_valid", 64'(a_out_valid), 64'd0);
      check("mid_rst_data", 64'(|a_out_data), 64'd0);
    end
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = fill(AR, 16'd5)[AR*DW-1:0];
    #1 check("mid_rst_accept", 64'(a_in_ready), 64'd1);
    for (int k = 1; k <= ALAT; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      if (k == ALAT) begin
        check("zero_w_valid", 64'(a_out_valid), 64'd1);
        check("zero_w_data", 64'(|a_out_data), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
